// File: rtl/match_pkg.sv
// Shared types and constants for the match-level sequencer.
package match_pkg;

    // Match sequencer states
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PLAY       = 2'd1,
        ST_ROUND_END  = 2'd2,
        ST_MATCH_OVER = 2'd3
    } state_t;

    // Champion encodings
    localparam logic [1:0] CH_NONE = 2'b00;
    localparam logic [1:0] CH_P1   = 2'b01;
    localparam logic [1:0] CH_P2   = 2'b10;

    // Active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;

endpackage

// File: rtl/score_seg7.sv
// Converts a 3-bit round score into an active-low seven-segment digit.
module score_seg7
    import match_pkg::*;
(
    input  logic [2:0] i_value,
    output logic [6:0] o_seg
);

    // Digit lookup; every 3-bit value has a pattern
    always_comb begin
        o_seg = SEG_0;
        case (i_value)
            3'd0: o_seg = SEG_0;
            3'd1: o_seg = SEG_1;
            3'd2: o_seg = SEG_2;
            3'd3: o_seg = SEG_3;
            3'd4: o_seg = SEG_4;
            3'd5: o_seg = SEG_5;
            3'd6: o_seg = SEG_6;
            3'd7: o_seg = SEG_7;
            default: o_seg = SEG_0;
        endcase
    end

endmodule

// File: rtl/match_controller.sv
// Match-level sequencer: starts a match, gates play, tallies round winners,
// clears the round detector between rounds and declares the champion.
module match_controller
    import match_pkg::*;
#(
    parameter int WIN_ROUNDS  = 3,
    parameter int HOLD_CYCLES = 4
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_win,
    input  logic       p2_win,
    output logic       play_en,
    output logic       round_reset,
    output logic [2:0] score1,
    output logic [2:0] score2,
    output logic       match_over,
    output logic [1:0] champion,
    output logic [6:0] HEX5,
    output logic [6:0] HEX4
);

    localparam int              CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [2:0]      WIN_VAL   = 3'(WIN_ROUNDS);

    state_t           r_state;
    logic [2:0]       r_score1;
    logic [2:0]       r_score2;
    logic [1:0]       r_champion;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_start_q;

    state_t           w_next_state;
    logic [2:0]       w_next_score1;
    logic [2:0]       w_next_score2;
    logic [1:0]       w_next_champion;
    logic [CNT_W-1:0] w_next_hold_cnt;
    logic             w_start_edge;
    logic [2:0]       w_p1_inc;
    logic [2:0]       w_p2_inc;

    // start_q resets high so a key held through reset is not seen as an edge
    assign w_start_edge = start & ~r_start_q;
    // A score only increments while below WIN_ROUNDS (<= 7), so no wrap occurs
    assign w_p1_inc     = r_score1 + 3'd1;
    assign w_p2_inc     = r_score2 + 3'd1;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_score1   <= 3'd0;
            r_score2   <= 3'd0;
            r_champion <= CH_NONE;
            r_hold_cnt <= '0;
            r_start_q  <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_score1   <= w_next_score1;
            r_score2   <= w_next_score2;
            r_champion <= w_next_champion;
            r_hold_cnt <= w_next_hold_cnt;
            r_start_q  <= start;
        end
    end

    // Next-state logic and Moore outputs; round_reset in ROUND_END depends on the counter
    always_comb begin
        w_next_state    = r_state;
        w_next_score1   = r_score1;
        w_next_score2   = r_score2;
        w_next_champion = r_champion;
        w_next_hold_cnt = '0;
        play_en         = 1'b0;
        round_reset     = 1'b0;
        match_over      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                round_reset = 1'b1;
                if (w_start_edge) begin
                    w_next_state    = ST_PLAY;
                    w_next_score1   = 3'd0;
                    w_next_score2   = 3'd0;
                    w_next_champion = CH_NONE;
                end
            end
            ST_PLAY: begin
                play_en = 1'b1;
                if (p1_win && p2_win) begin
                    w_next_state = ST_ROUND_END;
                end else if (p1_win) begin
                    w_next_score1 = w_p1_inc;
                    if (w_p1_inc == WIN_VAL) begin
                        w_next_state    = ST_MATCH_OVER;
                        w_next_champion = CH_P1;
                    end else begin
                        w_next_state = ST_ROUND_END;
                    end
                end else if (p2_win) begin
                    w_next_score2 = w_p2_inc;
                    if (w_p2_inc == WIN_VAL) begin
                        w_next_state    = ST_MATCH_OVER;
                        w_next_champion = CH_P2;
                    end else begin
                        w_next_state = ST_ROUND_END;
                    end
                end
            end
            ST_ROUND_END: begin
                round_reset = (r_hold_cnt == HOLD_LAST);
                if (r_hold_cnt == HOLD_LAST) begin
                    w_next_state = ST_PLAY;
                end else begin
                    w_next_hold_cnt = r_hold_cnt + 1'b1;
                end
            end
            ST_MATCH_OVER: begin
                match_over = 1'b1;
                if (w_start_edge) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign score1   = r_score1;
    assign score2   = r_score2;
    assign champion = r_champion;

    score_seg7 u_seg_p1 (
        .i_value (r_score1),
        .o_seg   (HEX5)
    );

    score_seg7 u_seg_p2 (
        .i_value (r_score2),
        .o_seg   (HEX4)
    );

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
Match-level sequencer for the two-player rhythm/tug-of-war game on DE1-SoC.
- Sits above the per-round victory detector.
- Starts a match on a start key, gates the playfield, and tallies round winners (first to WIN_ROUNDS).
- Clears the round detector between rounds and declares the champion.
- Drives two score digits on the HEX displays.

Parameters:
WIN_ROUNDS, 3, round wins needed to take the match; legal range 1..7.
HOLD_CYCLES, 4, cycles spent in ROUND_END showing the round result before the next round; legal range >= 1.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  start key, level, already synchronized upstream; rising edge detected internally
p1_win  input  1  round won by player 1, level, held by the round detector until round_reset
p2_win  input  1  round won by player 2, same rules as p1_win
play_en  output  1  high only in PLAY; gates playfield movement
round_reset  output  1  clear strobe/level to the round victory detector
score1  output  3  player 1 round wins
score2  output  3  player 2 round wins
match_over  output  1  high only in MATCH_OVER
champion  output  2  00 none, 01 player 1, 10 player 2
HEX5  output  7  active-low seven-seg digit of score1
HEX4  output  7  active-low seven-seg digit of score2

Behaviour:
- One clock (clk). Reset is synchronous, active-high: on a reset edge, state becomes IDLE.
- Reset values of every output/register:
  - score1 = score2 = 0, hold counter 0, champion 00.
  - match_over 0, play_en 0, round_reset 1.
  - HEX5 = HEX4 = 7'b1000000 (digit 0).
  - start_q = 1, so a start key held through reset does not trigger a start.
- States: IDLE, PLAY, ROUND_END, MATCH_OVER. Registered state; Moore outputs except where noted.
- start_edge = start & ~start_q.
- IDLE:
  - round_reset = 1, play_en = 0.
  - On start_edge: next state PLAY; score1, score2 and champion cleared on the same edge.
- PLAY:
  - play_en = 1, round_reset = 0. p1_win/p2_win are sampled only in this state; they are ignored in all other states.
  - Both wins asserted in the same cycle: tie; no score change; go to ROUND_END.
  - Exactly one win asserted: that score increments on the transition edge.
    - If the incremented value equals WIN_ROUNDS: go to MATCH_OVER, champion set on the same edge.
    - Otherwise: go to ROUND_END.
  - start_edge in PLAY is ignored.
- ROUND_END:
  - play_en = 0. The hold counter runs 0..HOLD_CYCLES-1, so the state lasts exactly HOLD_CYCLES cycles.
  - round_reset = 1 only in the cycle where counter == HOLD_CYCLES-1 (combinational on counter).
  - Next state PLAY; counter cleared.
  - start_edge is ignored.
- MATCH_OVER:
  - match_over = 1, play_en = 0, round_reset = 0 (the round detector keeps showing the final winner).
  - Scores and champion hold.
  - On start_edge: go to IDLE. Scores stay visible until the next IDLE -> PLAY transition.
- Scores saturate at WIN_ROUNDS; no wrap is possible by construction.
- HEX5/HEX4 are combinational from score1/score2 (digits 0..7).
- Reset in any state, including mid-ROUND_END or MATCH_OVER, takes effect on the next clk edge. Reset overrides start and win inputs in the same cycle.

Decomposition:
- Package match_pkg:
  - state enum.
  - champion encodings CH_NONE/CH_P1/CH_P2.
  - active-low seven-seg constants for digits 0-7.
- One sub-module, score_seg7: 3-bit value to 7-bit active-low segments. Instantiated twice.

Test Plan:
1. Reset 2 cycles, then start 0->1 -> PLAY on the next edge: play_en=1, round_reset=0, score1=score2=0, HEX5=HEX4=7'b1000000.
2. In PLAY, p1_win=1 for 1 cycle -> next cycle score1=1, HEX5=7'b1111001, play_en=0. ROUND_END lasts 4 cycles with round_reset=1 only in the 4th; play_en=1 the cycle after.
3. In PLAY, p1_win=p2_win=1 in the same cycle -> scores unchanged (0,0), ROUND_END entered, full 4-cycle hold, back to PLAY.
4. p2 wins 3 separate rounds -> score2=3, HEX4=7'b0110000, match_over=1, champion=10. A later p1_win=1 leaves score1=0.
5. start held high through reset and after -> stays IDLE with round_reset=1. A start pulse during ROUND_END is ignored. Reset asserted mid-ROUND_END -> IDLE next edge, scores 0, round_reset=1.
6. In MATCH_OVER, start edge -> IDLE (round_reset=1, scores still 0/3). A second start edge -> PLAY with score1=score2=0, champion=00.
